// File: rtl/uart_rx_byte.sv
// ============================================================================
// uart_rx_byte : 8N1 UART receiver with a single-entry valid/ready holding
//                register and one-cycle framing-error / overrun pulses.
// Revision     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_byte #(
   parameter int CLOCK_FREQUENCY = 100_000_000,
   parameter int BAUD_RATE       = 115200
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int c_DIV   = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int c_HALF  = c_DIV / 2;
   localparam int c_CNT_W = $clog2(c_DIV);

   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(c_HALF - 1);

   if (c_DIV < 4) begin : g_div_check
      $error("uart_rx_byte: CLOCK_FREQUENCY / BAUD_RATE must be at least 4");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [c_CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]           bit_q, bit_d;
   logic [7:0]           shreg_q, shreg_d;
   logic [7:0]           data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 sync1_q, rx_s_q, rx_d_q;

   // Synchroniser flops reset high so reset never looks like a start edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
         rx_d_q  <= 1'b1;
      end else begin
         sync1_q <= rxd;
         rx_s_q  <= sync1_q;
         rx_d_q  <= rx_s_q;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + c_CNT_W'(1);
      bit_d   = bit_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      if (valid_q && ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (rx_d_q && !rx_s_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == c_CNT_MID) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == c_CNT_LAST) begin
               cnt_d   = '0;
               shreg_d = {rx_s_q, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            if (cnt_q == c_CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (!rx_s_q) begin
                  ferr_d = 1'b1;
               end else if (!valid_q || ready) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
// ============================================================================
// tb_uart_rx_byte : scoreboard bench for uart_rx_byte (DIV=16, HALF=8).
// Revision        : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_byte;

   localparam int c_CF   = 1_600_000;
   localparam int c_BR   = 100_000;
   localparam int c_DIV  = c_CF / c_BR;
   localparam int c_HALF = c_DIV / 2;
   // Posedges from driving the start bit to the edge consuming the stop sample
   localparam int c_STOP_EDGE = 3 + c_HALF + 9 * c_DIV;

   localparam int K_BYTE = 0;
   localparam int K_FERR = 1;
   localparam int K_OVR  = 2;

   typedef struct {
      int         kind;
      logic [7:0] b;
   } ev_t;

   logic       CLK   = 1'b0;
   logic       RST_N = 1'b1;
   logic       rxd   = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   int         total = 0;
   int         bad   = 0;
   ev_t        exp_q[$];
   bit         hold_full = 1'b0;
   logic [7:0] hold_byte = 8'h00;

   uart_rx_byte #(
      .CLOCK_FREQUENCY(c_CF),
      .BAUD_RATE      (c_BR)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .rxd      (rxd),
      .data     (data),
      .valid    (valid),
      .ready    (ready),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input bit stop);
      rxd = 1'b0;
      tick(c_DIV);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(c_DIV);
      end
      rxd = stop;
      tick(c_DIV);
      rxd = 1'b1;
   endtask

   task automatic push(input int kind, input logic [7:0] b);
      ev_t e;
      e.kind = kind;
      e.b    = b;
      exp_q.push_back(e);
   endtask

   // Reference: what one frame does to a one-deep mailbox given the consumer
   // level at the stop sample and just after it.
   task automatic model_frame(input logic [7:0] b, input bit stop_ok,
                              input bit rdy_stop, input bit rdy_after);
      if (!stop_ok) begin
         push(K_FERR, 8'h00);
      end else if (hold_full && !rdy_stop) begin
         push(K_OVR, 8'h00);
      end else begin
         if (hold_full) push(K_BYTE, hold_byte);
         hold_full = 1'b1;
         hold_byte = b;
         if (rdy_after) begin
            push(K_BYTE, b);
            hold_full = 1'b0;
         end
      end
   endtask

   task automatic model_take();
      if (hold_full) push(K_BYTE, hold_byte);
      hold_full = 1'b0;
   endtask

   task automatic see(input int kind, input logic [7:0] b);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d data=%0h expected no event", kind, b);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (kind == K_BYTE && e.b !== b)) begin
            bad++;
            $display("FAIL event: got kind=%0d data=%0h expected kind=%0d data=%0h",
                     kind, b, e.kind, e.b);
         end
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   logic       p_valid = 1'b0, p_ready = 1'b0, p_ferr = 1'b0, p_ovr = 1'b0;
   logic [7:0] p_data  = 8'h00;

   initial begin
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            p_valid = 1'b0; p_ready = 1'b0; p_ferr = 1'b0; p_ovr = 1'b0;
         end else begin
            if (valid && ready) see(K_BYTE, data);
            if (frame_err) see(K_FERR, 8'h00);
            if (overrun)   see(K_OVR, 8'h00);
            if (p_ferr) chk("frame_err_width", {31'd0, frame_err}, 32'd0);
            if (p_ovr)  chk("overrun_width", {31'd0, overrun}, 32'd0);
            if (p_valid && !p_ready) begin
               chk("stall_valid_hold", {31'd0, valid}, 32'd1);
               chk("stall_data_hold", {24'd0, data}, {24'd0, p_data});
            end
            p_valid = valid; p_ready = ready; p_ferr = frame_err;
            p_ovr = overrun; p_data = data;
         end
      end
   end

   initial begin
      #(1_000_000);
      $display("FAIL watchdog: got no completion expected finish before 1ms");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      logic [7:0] rb;
      bit         ok;
      int         gap;

      #1 RST_N = 1'b0;
      tick(3);
      chk("reset_data", {24'd0, data}, 32'h00);
      chk("reset_valid", {31'd0, valid}, 32'd0);
      chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
      chk("reset_overrun", {31'd0, overrun}, 32'd0);
      RST_N = 1'b1;
      ready = 1'b1;
      tick(5);

      // Single byte with latency measurement
      model_frame(8'hA5, 1'b1, 1'b1, 1'b1);
      fork
         send(8'hA5, 1'b1);
         begin
            cyc = 0;
            while (cyc < 300) begin
               @(posedge CLK); #1;
               cyc++;
               if (valid) break;
            end
            total++;
            if (cyc < c_STOP_EDGE - 2 || cyc > c_STOP_EDGE + 2) begin
               bad++;
               $display("FAIL latency: got %0d cycles expected %0d +/-2", cyc, c_STOP_EDGE);
            end
            tick(1);
            chk("valid_one_cycle", {31'd0, valid}, 32'd0);
         end
      join
      tick(c_DIV);

      // Back-to-back with stalled consumer
      ready = 1'b0;
      model_frame(8'h55, 1'b1, 1'b0, 1'b0);
      send(8'h55, 1'b1);
      chk("stall_first_valid", {31'd0, valid}, 32'd1);
      chk("stall_first_data", {24'd0, data}, {24'd0, hold_byte});
      model_frame(8'h0F, 1'b1, 1'b0, 1'b0);
      send(8'h0F, 1'b1);
      chk("overrun_keeps_data", {24'd0, data}, {24'd0, hold_byte});
      model_take();
      ready = 1'b1;
      tick(1);
      chk("valid_falls_on_take", {31'd0, valid}, 32'd0);
      tick(c_DIV);

      // Framing error, then recovery after two idle bits
      model_frame(8'h3C, 1'b0, 1'b1, 1'b1);
      send(8'h3C, 1'b0);
      chk("ferr_no_valid", {31'd0, valid}, 32'd0);
      tick(2 * c_DIV);
      model_frame(8'h81, 1'b1, 1'b1, 1'b1);
      send(8'h81, 1'b1);
      tick(c_DIV);

      // Glitch rejection followed closely by a real frame
      rxd = 1'b0;
      tick(4);
      rxd = 1'b1;
      tick(c_DIV - 4);
      model_frame(8'h96, 1'b1, 1'b1, 1'b1);
      send(8'h96, 1'b1);
      tick(c_DIV);

      // Simultaneous load and take on the stop-sample edge
      ready = 1'b0;
      model_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send(8'h11, 1'b1);
      model_frame(8'h22, 1'b1, 1'b1, 1'b0);
      fork
         send(8'h22, 1'b1);
         begin
            tick(c_STOP_EDGE - 1);
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
         end
      join
      chk("simul_valid", {31'd0, valid}, 32'd1);
      chk("simul_data", {24'd0, data}, {24'd0, hold_byte});

      // Reset in the middle of data bit 3 of 8'hFF
      rxd = 1'b0;
      tick(c_DIV);
      rxd = 1'b1;
      tick(3 * c_DIV + c_HALF);
      #2 RST_N = 1'b0;
      hold_full = 1'b0;
      #1;
      chk("async_reset_data", {24'd0, data}, 32'h00);
      chk("async_reset_valid", {31'd0, valid}, 32'd0);
      chk("async_reset_ferr", {31'd0, frame_err}, 32'd0);
      chk("async_reset_ovr", {31'd0, overrun}, 32'd0);
      tick(3);
      RST_N = 1'b1;
      tick(2 * c_DIV);
      ready = 1'b1;
      model_frame(8'h7E, 1'b1, 1'b1, 1'b1);
      send(8'h7E, 1'b1);
      tick(c_DIV);

      // Random frames with occasional bad stop bits and random gaps
      for (int n = 0; n < 12; n++) begin
         rb  = 8'($urandom);
         ok  = ($urandom_range(0, 4) != 0);
         gap = $urandom_range(0, 2);
         if (!ok && gap == 0) gap = 1;
         model_frame(rb, ok, 1'b1, 1'b1);
         send(rb, ok);
         tick(gap * c_DIV);
      end

      tick(20);
      chk("leftover_expected", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_rx_byte.md
# uart_rx_byte

Receive-side UART deframer for the PYNQ UART path: takes the raw asynchronous RxD pin (HD_GPIO_2), synchronises it, detects 8N1 frames and presents each received byte on a single-entry valid/ready holding register. It sits directly upstream of the echo/command logic, which consumes bytes through the handshake. It also reports framing errors and overruns as one-cycle pulses so the top level can drive LED status.

## Interface

Parameters:
- CLOCK_FREQUENCY, default 100_000_000: CLK frequency in Hz.
- BAUD_RATE, default 115200: line rate in bit/s.
- Derived constants:
  - DIV = CLOCK_FREQUENCY / BAUD_RATE, integer, truncated. DIV must be >= 4, checked at elaboration.
  - HALF = DIV / 2, truncated.

Ports:
- CLK  in  1  system clock, the only clock.
- RST_N  in  1  reset, asynchronous and active-low.
- rxd  in  1  raw serial input, asynchronous to CLK, idle high.
- data  out  8  received byte, valid while valid=1.
- valid  out  1  holding register full.
- ready  in  1  consumer accepts; transfer occurs when valid && ready at a rising edge of CLK.
- frame_err  out  1  one-cycle pulse, stop bit sampled low.
- overrun  out  1  one-cycle pulse, byte dropped because the holding register was full.

## Operation

- rxd passes through a 2-FF synchroniser (both flops reset to 1) to give rx_s. A further flop holds rx_d, the previous value of rx_s. All decisions use rx_s only.
- Bit counter: 0..DIV-1. Bit index: 0..7.
- State machine:
  - IDLE: moves to START when rx_d=1 and rx_s=0 (falling edge). Counter cleared to 0.
  - START: when counter = HALF-1, sample rx_s.
    - Sample 1: treat as a glitch and return to IDLE.
    - Sample 0: clear counter and bit index, go to DATA.
  - DATA: when counter = DIV-1, shift rx_s into the shift register LSB-first (shreg <= {rx_s, shreg[7:1]}), clear counter and increment bit index. After bit 7 is taken, go to STOP.
  - STOP: when counter = DIV-1, sample rx_s, then go to IDLE on the same edge. The state machine returns to IDLE at mid-stop-bit so it can resynchronise on a back-to-back start bit.
- Stop-bit resolution:
  - Stop sample 1, and either valid=0 or ready=1 in that cycle: load data <= shreg and set valid=1.
  - Stop sample 1, valid=1 and ready=0: pulse overrun. The byte is discarded and data/valid are unchanged.
  - Stop sample 0: pulse frame_err and discard the byte. A line held low (break) cannot restart reception until rx_s returns high, because a falling edge is required.
- Handshake: valid falls on the edge where valid && ready, unless a new byte loads on that same edge, in which case valid stays 1 and data updates. data is stable while valid=1 and ready=0.
- Reset mid-frame: the state machine returns to IDLE immediately and the partial byte is lost. After RST_N deasserts, the first falling edge starts a new frame.

## Timing

- Reset values:
  - state = IDLE; counter and bit index = 0.
  - synchroniser flops and rx_d = 1.
  - shreg = 0, data = 8'h00, valid = 0, frame_err = 0, overrun = 0.
- Sample points, measured from the cycle rx_s first reads 0:
  - start: HALF cycles later;
  - data bit k: HALF + (k+1)*DIV;
  - stop: HALF + 9*DIV.
- valid, frame_err and overrun change on the edge that consumes the stop sample. frame_err and overrun are high for exactly one cycle.
- Pin-to-valid latency: 2 (synchroniser) + 1 (edge detect) + HALF + 9*DIV cycles. The bench tolerates ±2 cycles.
- Baud tolerance: mid-bit sampling with no re-alignment inside a frame gives about ±4.5% total error.
- No combinational path from ready to valid/data; all outputs are registered.

## Test plan

All scenarios use CLOCK_FREQUENCY=1_600_000 and BAUD_RATE=100_000, giving DIV=16 and HALF=8. The bench drives rxd with ideal 16-cycle bits.

- **Single byte:** send 8'hA5 with ready held 1. Required: valid pulses for one cycle with data=8'hA5 about 155 cycles after the start edge; frame_err=0; overrun=0.
- **Back-to-back, stalled consumer:** send 8'h55 then 8'h0F with no idle gap and ready=0. Required: data=8'h55 and valid=1 after the first frame. At the second stop: overrun pulses and data stays 8'h55. Then raise ready: valid falls on the next edge.
- **Framing error:** send 8'h3C with the stop bit forced 0. Required: frame_err pulses one cycle and valid stays 0. Then send 8'h81 after 2 idle bits: it is received correctly.
- **Glitch rejection:** a 4-cycle low pulse on an idle line. Required: no valid and no frame_err, and the state machine is back in IDLE before the pulse's start sample window ends.
- **Simultaneous load and take:** valid=1 holding 8'h11; ready=1 exactly on the stop-sample cycle of 8'h22. Required: valid stays 1, data becomes 8'h22, no overrun.
- **Reset mid-frame:** assert RST_N=0 during data bit 3 of 8'hFF. Required: all outputs return to reset values asynchronously. After release, the next frame 8'h7E is received intact.
